// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller for an external dual-port RAM with a registered read port.
// Owns the read/write pointers and the occupancy count, and flags rejected pushes and pops.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  push_acc;
  logic                  pop_acc;

  assign full  = (count_r == DEPTH_CNT);
  assign empty = (count_r == '0);
  assign count = count_r;

  // Full blocks pushes even alongside a pop so the RAM never sees a same-address
  // read and write on one edge; empty blocks pops even alongside a push (no bypass).
  assign push_acc = wr_en & ~full;
  assign pop_acc  = rd_en & ~empty;

  assign ram_data       = wr_data;
  assign ram_write_addr = wr_ptr;
  assign ram_we         = push_acc;
  assign ram_read_addr  = rd_ptr;
  assign rd_data        = ram_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      unique case ({push_acc, pop_acc})
        2'b10:   count_r <= count_r + (ADDR_WIDTH+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_WIDTH+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // The RAM registers q on the same edge the pop is accepted, so valid trails by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= pop_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM plus a queue-based FIFO reference model,
// driven by directed scenarios and biased random push/pop traffic.
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] ram_write_addr;
  logic          ram_we;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_q;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow),
    .ram_data(ram_data), .ram_write_addr(ram_write_addr), .ram_we(ram_we),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // External 64x8 RAM: synchronous write, registered read returning pre-write contents.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_write_addr] <= ram_data;
    ram_q <= mem[ram_read_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] model_q [$];
  int unsigned   wr_total;
  int unsigned   rd_total;
  bit            exp_valid;
  bit            exp_ovf;
  bit            exp_udf;
  logic [DW-1:0] exp_rdata;

  task automatic model_reset();
    model_q.delete();
    wr_total  = 0;
    rd_total  = 0;
    exp_valid = 0;
    exp_ovf   = 0;
    exp_udf   = 0;
    exp_rdata = '0;
  endtask

  // Called just after a falling edge: drive, check, advance model, wait one cycle.
  task automatic step(input bit we, input bit rd, input logic [DW-1:0] d);
    int  sz;
    bit  push_ok;
    bit  pop_ok;
    wr_en   = we;
    rd_en   = rd;
    wr_data = d;
    #1;
    sz      = model_q.size();
    push_ok = we && (sz < DEPTH);
    pop_ok  = rd && (sz > 0);
    check_eq("count",     32'(count),          32'(sz));
    check_eq("full",      32'(full),           32'(sz == DEPTH));
    check_eq("empty",     32'(empty),          32'(sz == 0));
    check_eq("ram_we",    32'(ram_we),         32'(push_ok));
    check_eq("ram_data",  32'(ram_data),       32'(d));
    check_eq("wr_addr",   32'(ram_write_addr), wr_total % DEPTH);
    check_eq("rd_addr",   32'(ram_read_addr),  rd_total % DEPTH);
    check_eq("rd_valid",  32'(rd_valid),       32'(exp_valid));
    check_eq("overflow",  32'(overflow),       32'(exp_ovf));
    check_eq("underflow", 32'(underflow),      32'(exp_udf));
    if (exp_valid) check_eq("rd_data", 32'(rd_data), 32'(exp_rdata));
    exp_ovf   = we && (sz == DEPTH);
    exp_udf   = rd && (sz == 0);
    exp_valid = pop_ok;
    if (pop_ok) begin
      exp_rdata = model_q.pop_front();
      rd_total++;
    end
    if (push_ok) begin
      model_q.push_back(d);
      wr_total++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    model_reset();

    // 1: reset state
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_empty", 32'(empty),    32'd1);
    check_eq("rst_full",  32'(full),     32'd0);
    check_eq("rst_count", 32'(count),    32'd0);
    check_eq("rst_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_we",    32'(ram_we),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    // 2: three pushes then three consecutive pops
    step(1, 0, 8'h11);
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    repeat (3) step(0, 1, 8'h00);
    repeat (2) step(0, 0, 8'h00);

    // 3: fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) step(1, 0, DW'(i));
    step(1, 0, 8'hAA);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00);
    repeat (2) step(0, 0, 8'h00);

    // 4: simultaneous push/pop from empty
    step(1, 1, 8'h5A);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // 5: steady occupancy of 10 across pointer wrap
    for (int i = 0; i < 10; i++) step(1, 0, DW'($urandom));
    for (int i = 0; i < 100; i++) begin
      step(1, 1, DW'($urandom));
      check_eq("steady_cnt", 32'(count), 32'd10);
    end
    for (int i = 0; i < 10; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Random traffic in phases biased toward filling, draining and balance
    for (int ph = 0; ph < 6; ph++) begin
      int unsigned wp;
      int unsigned rp;
      wp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 20 : 50;
      rp = (ph % 3 == 0) ? 20 : (ph % 3 == 1) ? 85 : 50;
      for (int i = 0; i < 150; i++)
        step($urandom_range(99) < wp, $urandom_range(99) < rp, DW'($urandom));
    end

    // 6: asynchronous reset with count=20 and a pop in flight
    while (model_q.size() > 0) step(0, 1, 8'h00);
    for (int i = 0; i < 20; i++) step(1, 0, DW'($urandom));
    step(0, 1, 8'h00);
    wr_en = 1'b0;
    rd_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_count", 32'(count),     32'd0);
    check_eq("arst_empty", 32'(empty),     32'd1);
    check_eq("arst_full",  32'(full),      32'd0);
    check_eq("arst_valid", 32'(rd_valid),  32'd0);
    check_eq("arst_ovf",   32'(overflow),  32'd0);
    check_eq("arst_udf",   32'(underflow), 32'd0);
    check_eq("arst_we",    32'(ram_we),    32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("arst_valid2", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 8'h77);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Single-clock FIFO controller that drives an external 64x8 dual-port RAM through the RAM's data, write_addr, we, read_addr and q pins, with both RAM clocks tied to clk. It owns the write and read pointers and the occupancy count. It presents a push/pop interface to producer and consumer logic, and it accounts for the RAM's one-cycle registered read. It sits between stream sources or sinks and the RAM macro.

Parameters:
DATA_WIDTH, 8, data word width; must match the RAM width.
ADDR_WIDTH, 6, RAM address width.
DEPTH, 64, number of words; equals 2**ADDR_WIDTH.

Ports:
clk  input  1  single clock for the controller and both RAM ports.
rst_n  input  1  asynchronous active-low reset.
wr_en  input  1  producer push request.
wr_data  input  DATA_WIDTH  push data.
rd_en  input  1  consumer pop request.
rd_data  output  DATA_WIDTH  pop data; equals ram_q; meaningful only when rd_valid=1.
rd_valid  output  1  pop data valid this cycle.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse when a push is rejected.
underflow  output  1  one-cycle pulse when a pop is rejected.
ram_data  output  DATA_WIDTH  to RAM data; combinational copy of wr_data.
ram_write_addr  output  ADDR_WIDTH  to RAM write_addr; equals wr_ptr.
ram_we  output  1  to RAM we; equals push accepted.
ram_read_addr  output  ADDR_WIDTH  to RAM read_addr; equals rd_ptr.
ram_q  input  DATA_WIDTH  from RAM q.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0. Therefore empty=1, full=0, ram_we=0.
- Reset applied mid-operation discards any pending read. RAM contents are not cleared.
- push_acc = wr_en & ~full. A push is rejected when full, even if a pop is accepted in the same cycle. This avoids same-address read/write on the same edge.
- pop_acc = rd_en & ~empty. A pop is rejected when empty, even if a push arrives in the same cycle; there is no bypass.
- ram_we = push_acc (combinational). On the same edge the RAM stores wr_data at wr_ptr, and wr_ptr increments mod DEPTH.
- ram_read_addr = rd_ptr. The RAM registers q on every edge. On pop_acc, rd_ptr increments mod DEPTH, and rd_valid is set to 1 for the next cycle; otherwise rd_valid is 0.
- Pop latency: rd_en accepted in cycle N gives rd_valid=1 and the data in cycle N+1.
- Write-to-read latency: a push in cycle N clears empty in cycle N+1. A pop in cycle N+1 yields data in cycle N+2.
- Count update:
  - push_acc and not pop_acc: count+1.
  - pop_acc and not push_acc: count-1.
  - both: count unchanged.
- full and empty are decoded combinationally from the registered count.
- overflow is registered: 1 in the cycle after wr_en & full. underflow is registered: 1 in the cycle after rd_en & empty. Neither is sticky.
- Pointer wrap: both pointers roll 63 -> 0 without disturbing count or flags.
- Back-to-back pops on consecutive cycles stream one word per cycle with rd_valid held high.
- Data order is strictly first-in first-out.

Test Plan:
1. Reset, then idle -> empty=1, full=0, count=0, rd_valid=0, ram_we=0.
2. Push 0x11, 0x22, 0x33, then pop 3 consecutive cycles -> rd_valid high for 3 cycles, each starting one cycle after its pop, carrying 0x11, 0x22, 0x33; empty=1 afterwards.
3. Push 64 words (0x00..0x3F), then push 0xAA -> full=1, count=64, overflow pulses for one cycle, ram_we=0 for 0xAA. Then pop all -> 0x00..0x3F in order.
4. From empty, rd_en=1 and wr_en=1 with 0x5A in the same cycle -> underflow pulses, push accepted, count=1. Pop next cycle -> 0x5A.
5. Hold count=10 with simultaneous push and pop for 100 cycles across pointer wrap -> count stays 10, and the output sequence matches the input sequence delayed by 10.
6. Assert rst_n=0 asynchronously with count=20 and a pop in flight -> flags and count reset immediately, rd_valid=0 next cycle. After release, push 0x77 then pop -> 0x77.
